// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches instruction words, and
// presents them to decode through an instruction register with a
// valid/ready handshake. PC redirects from branch/jump resolution take
// priority over everything else.
// Optional misaligned-target fault detection: define IFU_MISALIGN_CHECK_EN.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                    MEM_LATENCY = 0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = 32'h0000_0033
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] ir_out,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_fault
);

`ifdef IFU_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;
`endif

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [3:0]            wait_cnt;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] target_pc;

  // The address bus always shows the fetch PC (the next PC while holding)
  assign imem_addr = pc;

`ifdef IFU_MISALIGN_CHECK_EN
  logic target_bad;
  assign target_pc  = redirect_pc;
  assign target_bad = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign target_pc       = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign fetch_fault     = 1'b0;
`endif

  // Next-state logic and capture strobe; redirect overrides every state
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    if (redirect) begin
`ifdef IFU_MISALIGN_CHECK_EN
      state_next = target_bad ? S_FAULT : S_FETCH;
`else
      state_next = S_FETCH;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (LAT == 4'd0) begin
            capture    = 1'b1;
            state_next = S_HOLD;
          end else begin
            state_next = S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == LAT) begin
            capture    = 1'b1;
            state_next = S_HOLD;
          end
        end
        S_HOLD: begin
          if (ir_valid && ir_ready) begin
            state_next = S_FETCH;
          end
        end
`ifdef IFU_MISALIGN_CHECK_EN
        S_FAULT: begin
          state_next = S_FAULT;
        end
`endif
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // PC, instruction register, handshake flag and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir_out   <= NOP_WORD;
      ir_pc    <= RESET_PC;
      ir_valid <= 1'b0;
      wait_cnt <= 4'd0;
    end else if (redirect) begin
      pc       <= target_pc;
      ir_out   <= NOP_WORD;
      ir_valid <= 1'b0;
      wait_cnt <= 4'd0;
    end else begin
      if (capture) begin
        ir_out   <= imem_data;
        ir_pc    <= pc;
        pc       <= pc + ADDR_WIDTH'(4);
        ir_valid <= 1'b1;
        wait_cnt <= 4'd0;
      end else if (state == S_FETCH) begin
        wait_cnt <= 4'd1;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      if (state == S_HOLD && ir_valid && ir_ready) begin
        ir_valid <= 1'b0;
      end
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  // Fault flag follows the alignment of the most recent redirect target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_fault <= 1'b0;
    end else if (redirect) begin
      fetch_fault <= target_bad;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
// Two instances: u_lat0 (combinational memory) and u_lat2 (two wait cycles).
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;

  logic [31:0] imem_addr0, imem_data0, ir_out0, ir_pc0, redirect_pc0;
  logic        ir_valid0, ir_ready0, redirect0, fetch_fault0;

  logic [31:0] imem_addr2, imem_data2, ir_out2, ir_pc2, redirect_pc2;
  logic        ir_valid2, ir_ready2, redirect2, fetch_fault2;

  int checks   = 0;
  int failures = 0;

  // Instruction memory contents, addressed by byte address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_10b7;
      32'h0000_0004: mem_word = 32'h0002_0137;
      32'h0000_0008: mem_word = 32'h0000_81b7;
      32'h0000_001C: mem_word = 32'h00c0_0093;
      32'h0000_0020: mem_word = 32'h0010_0113;
      32'hFFFF_FFFC: mem_word = 32'h0000_0013;
      default:       mem_word = {a[15:0], 16'hBEEF};
    endcase
  endfunction

  assign imem_data0 = mem_word(imem_addr0);
  assign imem_data2 = mem_word(imem_addr2);

  instruction_fetch_unit #(.MEM_LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr0), .imem_data(imem_data0),
    .ir_out(ir_out0), .ir_pc(ir_pc0), .ir_valid(ir_valid0), .ir_ready(ir_ready0),
    .redirect(redirect0), .redirect_pc(redirect_pc0), .fetch_fault(fetch_fault0)
  );

  instruction_fetch_unit #(.MEM_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .ir_out(ir_out2), .ir_pc(ir_pc2), .ir_valid(ir_valid2), .ir_ready(ir_ready2),
    .redirect(redirect2), .redirect_pc(redirect_pc2), .fetch_fault(fetch_fault2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 time unit past it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst          = 1'b1;
    ir_ready0    = 1'b1;
    redirect0    = 1'b0;
    redirect_pc0 = 32'h0;
    ir_ready2    = 1'b0;
    redirect2    = 1'b0;
    redirect_pc2 = 32'h0;

    // Reset held for three cycles
    repeat (3) applyStimulus();
    checkOutput("rst_addr",  imem_addr0, 32'h0);
    checkOutput("rst_valid", {31'b0, ir_valid0}, 32'h0);
    checkOutput("rst_ir",    ir_out0, 32'h0000_0033);
    checkOutput("rst_fault", {31'b0, fetch_fault0}, 32'h0);
    checkOutput("rst_valid2", {31'b0, ir_valid2}, 32'h0);
    rst = 1'b0;

    // Sequential fetch, one instruction every two cycles
    applyStimulus();
    checkOutput("seq0_ir",    ir_out0, 32'h0000_10b7);
    checkOutput("seq0_pc",    ir_pc0, 32'h0);
    checkOutput("seq0_valid", {31'b0, ir_valid0}, 32'h1);
    applyStimulus();
    checkOutput("seq0_drop",  {31'b0, ir_valid0}, 32'h0);
    checkOutput("seq1_addr",  imem_addr0, 32'h4);
    applyStimulus();
    checkOutput("seq1_ir",    ir_out0, 32'h0002_0137);
    checkOutput("seq1_pc",    ir_pc0, 32'h4);
    checkOutput("seq1_valid", {31'b0, ir_valid0}, 32'h1);

    // Backpressure: IR must hold for five cycles
    ir_ready0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("bp_valid", {31'b0, ir_valid0}, 32'h1);
      checkOutput("bp_ir",    ir_out0, 32'h0002_0137);
      checkOutput("bp_addr",  imem_addr0, 32'h8);
    end
    ir_ready0 = 1'b1;
    applyStimulus();
    checkOutput("bp_release", {31'b0, ir_valid0}, 32'h0);
    applyStimulus();
    checkOutput("seq2_ir", ir_out0, 32'h0000_81b7);
    checkOutput("seq2_pc", ir_pc0, 32'h8);

    // Redirect coincident with a handshake
    redirect0    = 1'b1;
    redirect_pc0 = 32'h0000_001C;
    applyStimulus();
    redirect0 = 1'b0;
    checkOutput("rdhs_valid", {31'b0, ir_valid0}, 32'h0);
    checkOutput("rdhs_flush", ir_out0, 32'h0000_0033);
    checkOutput("rdhs_addr",  imem_addr0, 32'h1C);
    applyStimulus();
    checkOutput("rdhs_ir",    ir_out0, 32'h00c0_0093);
    checkOutput("rdhs_pc",    ir_pc0, 32'h1C);

    // PC wrap from the top of the address space
    redirect0    = 1'b1;
    redirect_pc0 = 32'hFFFF_FFFC;
    applyStimulus();
    redirect0 = 1'b0;
    checkOutput("wrap_addr0", imem_addr0, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("wrap_ir",    ir_out0, 32'h0000_0013);
    checkOutput("wrap_pc",    ir_pc0, 32'hFFFF_FFFC);
    checkOutput("wrap_addr1", imem_addr0, 32'h0);
    applyStimulus();
    checkOutput("wrap_addr2", imem_addr0, 32'h0);
    applyStimulus();
    checkOutput("wrap_next_pc", ir_pc0, 32'h0);
    checkOutput("wrap_next_ir", ir_out0, 32'h0000_10b7);

    // Misaligned redirect target
    redirect0    = 1'b1;
    redirect_pc0 = 32'h0000_0022;
    applyStimulus();
    redirect0 = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    checkOutput("mis_fault", {31'b0, fetch_fault0}, 32'h1);
    checkOutput("mis_addr",  imem_addr0, 32'h22);
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput("mis_hold_valid", {31'b0, ir_valid0}, 32'h0);
      checkOutput("mis_hold_fault", {31'b0, fetch_fault0}, 32'h1);
    end
    redirect0    = 1'b1;
    redirect_pc0 = 32'h0000_0020;
    applyStimulus();
    redirect0 = 1'b0;
    checkOutput("mis_clear", {31'b0, fetch_fault0}, 32'h0);
    checkOutput("mis_resume_addr", imem_addr0, 32'h20);
    applyStimulus();
`else
    checkOutput("align_fault", {31'b0, fetch_fault0}, 32'h0);
    checkOutput("align_addr",  imem_addr0, 32'h20);
    applyStimulus();
`endif
    checkOutput("mis_next_pc",    ir_pc0, 32'h20);
    checkOutput("mis_next_ir",    ir_out0, 32'h0010_0113);
    checkOutput("mis_next_valid", {31'b0, ir_valid0}, 32'h1);

    // Latency-2 instance: first instruction was fetched and held meanwhile
    checkOutput("l2_hold_ir",    ir_out2, 32'h0000_10b7);
    checkOutput("l2_hold_pc",    ir_pc2, 32'h0);
    checkOutput("l2_hold_valid", {31'b0, ir_valid2}, 32'h1);
    ir_ready2 = 1'b1;
    applyStimulus();
    ir_ready2 = 1'b0;
    checkOutput("l2_consume", {31'b0, ir_valid2}, 32'h0);
    checkOutput("l2_addr4",   imem_addr2, 32'h4);
    applyStimulus();
    // Now in WAIT for address 4; redirect abandons it
    redirect2    = 1'b1;
    redirect_pc2 = 32'h0000_001C;
    applyStimulus();
    redirect2 = 1'b0;
    checkOutput("l2_rd_addr",  imem_addr2, 32'h1C);
    checkOutput("l2_rd_flush", ir_out2, 32'h0000_0033);
    applyStimulus();
    checkOutput("l2_w1_valid", {31'b0, ir_valid2}, 32'h0);
    applyStimulus();
    checkOutput("l2_w2_valid", {31'b0, ir_valid2}, 32'h0);
    checkOutput("l2_w2_ir",    ir_out2, 32'h0000_0033);
    applyStimulus();
    checkOutput("l2_cap_valid", {31'b0, ir_valid2}, 32'h1);
    checkOutput("l2_cap_ir",    ir_out2, 32'h00c0_0093);
    checkOutput("l2_cap_pc",    ir_pc2, 32'h1C);

    // Asynchronous reset while both instances hold a valid IR
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid0", {31'b0, ir_valid0}, 32'h0);
    checkOutput("arst_ir0",    ir_out0, 32'h0000_0033);
    checkOutput("arst_addr0",  imem_addr0, 32'h0);
    checkOutput("arst_valid2", {31'b0, ir_valid2}, 32'h0);
    checkOutput("arst_pc2",    ir_pc2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
